// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared states, constants and helpers for the UART frame transmitter
package uart_frame_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_e;
  localparam int MAX_BYTES = 64;
  localparam int MAX_W = 8 * MAX_BYTES;
  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction
  function automatic logic parity_bit(input logic [7:0] b, input logic odd);
    return ^b ^ odd;
  endfunction
  function automatic logic [7:0] checksum(input logic [MAX_W-1:0] v, input int n);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < MAX_BYTES; i++) if (i < n) s = s + v[8*i +: 8];
    return s;
  endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serialises one byte with start, parity and stop bits; a start
// presented during the last stop cycle chains the next byte with no idle gap.
module uart_byte_tx import uart_frame_pkg::*; #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic par_q, par_d, tx_q, tx_d, tick;
  always_comb begin
    tick = cnt_q == CW'(CLKS_PER_BIT - 1);
    done = state_q == STOP && tick && bit_q == 3'(STOP_BITS - 1);
    state_d = state_q;
    cnt_d = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    par_d = par_q;
    tx_d = tx_q;
    if (tick)
      case (state_q)
        START: begin
          state_d = DATA;
          tx_d = sh_q[0];
        end
        DATA: begin
          sh_d = {1'b1, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          state_d = bit_q == 3'd7 ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
          tx_d = bit_q == 3'd7 ? (PARITY_EN != 0 ? par_q : 1'b1) : sh_q[1];
        end
        PARITY: begin
          state_d = STOP;
          tx_d = 1'b1;
        end
        STOP: begin
          bit_d = done ? '0 : bit_q + 1'b1;
          state_d = done ? IDLE : STOP;
        end
        default: ;
      endcase
    if (start && (state_q == IDLE || done)) begin
      state_d = START;
      cnt_d = '0;
      bit_d = '0;
      sh_d = byte_in;
      par_d = parity_bit(byte_in, PARITY_ODD != 0);
      tx_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      par_q <= par_d;
      tx_q <= tx_d;
    end
  assign tx = tx_q;
endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: sends optional header, payload (MSB byte first) and optional
// checksum as one back-to-back UART frame behind a valid/ready handshake.
module uart_frame_tx import uart_frame_pkg::*; #(
  parameter int         CLOCK_FREQ  = 50_000_000,
  parameter int         BAUD_RATE   = 115200,
  parameter int         NUM_BYTES   = 4,
  parameter int         HEADER_EN   = 1,
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter int         CHECKSUM_EN = 1,
  parameter int         PARITY_EN   = 0,
  parameter int         PARITY_ODD  = 0,
  parameter int         STOP_BITS   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_BYTES-1:0] data_array,
  input  logic                   send_valid,
  output logic                   send_ready,
  output logic                   uart_tx,
  output logic                   busy,
  output logic                   frame_done
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int TOTAL = HEADER_EN + NUM_BYTES + CHECKSUM_EN;
  localparam int IW = $clog2(TOTAL + 1);
  state_e state_q, state_d;
  logic [8*NUM_BYTES-1:0] shadow_q, shadow_d, src;
  logic [IW-1:0] idx_q, idx_d;
  logic ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic hs, byte_start, byte_done;
  logic [7:0] byte_val;
  int pos;
  always_comb begin
    hs = send_valid && ready_q;
    // the first byte leaves on the handshake edge, before the shadow holds the data
    src = hs ? data_array : shadow_q;
    pos = int'(idx_q) - HEADER_EN;
    byte_val = (HEADER_EN != 0 && idx_q == '0) ? HEADER_BYTE :
               pos < NUM_BYTES ? 8'(src >> (8 * (NUM_BYTES - 1 - pos))) :
               checksum(MAX_W'(src), NUM_BYTES);
    state_d = state_q;
    shadow_d = shadow_q;
    idx_d = idx_q;
    ready_d = ready_q;
    busy_d = busy_q;
    done_d = 1'b0;
    byte_start = 1'b0;
    case (state_q)
      IDLE: if (hs) begin
        state_d = DATA;
        shadow_d = data_array;
        idx_d = IW'(1);
        byte_start = 1'b1;
        ready_d = 1'b0;
        busy_d = 1'b1;
      end
      DATA: if (byte_done) begin
        state_d = idx_q == IW'(TOTAL) ? DONE : DATA;
        done_d = idx_q == IW'(TOTAL);
        busy_d = idx_q != IW'(TOTAL);
        idx_d = idx_q == IW'(TOTAL) ? '0 : idx_q + 1'b1;
        byte_start = idx_q != IW'(TOTAL);
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      shadow_q <= '0;
      idx_q <= '0;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shadow_q <= shadow_d;
      idx_q <= idx_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .PARITY_EN(PARITY_EN),
    .PARITY_ODD(PARITY_ODD),
    .STOP_BITS(STOP_BITS)
  ) u_byte (
    .clk(clk),
    .rst(rst),
    .start(byte_start),
    .byte_in(byte_val),
    .tx(uart_tx),
    .done(byte_done)
  );
  assign send_ready = ready_q;
  assign busy = busy_q;
  assign frame_done = done_q;
endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised UART frame transmitter that serialises a configurable-length byte array as one framed packet: optional header byte, payload bytes, optional 8-bit checksum, with configurable parity and stop bits. It replaces the fixed 32-bit array transmitter behind the DE1-SoC top level, driving a GPIO pin toward a host UART. A valid/ready handshake lets upstream logic queue frames back-to-back.

## Interface
- CLOCK_FREQ, 50_000_000 — clk frequency in Hz
- BAUD_RATE, 115200 — line rate; CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer, truncated; 434 at defaults; must be ≥ 2)
- NUM_BYTES, 4 — payload bytes per frame, ≥ 1
- HEADER_EN, 1 — prepend HEADER_BYTE
- HEADER_BYTE, 8'hA5 — header value
- CHECKSUM_EN, 1 — append checksum byte
- PARITY_EN, 0 — insert parity bit after data bits
- PARITY_ODD, 0 — 0 = even, 1 = odd parity
- STOP_BITS, 1 — 1 or 2
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- data_array  input  8*NUM_BYTES  payload; sampled only on handshake
- send_valid  input  1  request to send data_array
- send_ready  output  1  high when idle and able to accept a frame
- uart_tx  output  1  serial line, idle high
- busy  output  1  high from handshake until end of final stop bit
- frame_done  output  1  single-cycle pulse after the final stop bit

## Operation
- Reset (async, any time incl. mid-frame): uart_tx=1, send_ready=1, busy=0, frame_done=0, all counters cleared, state IDLE. Partial frame is abandoned.
- Handshake: send_valid && send_ready in a cycle latches data_array into a shadow register; send_valid while busy is ignored (no queueing).
- Byte order: header (if enabled), payload bytes most-significant byte first (data_array[8*NUM_BYTES-1 -: 8] first), checksum (if enabled).
- Checksum: sum of payload bytes modulo 256; header excluded.
- Per byte: start bit 0, 8 data bits LSB first, parity bit (if PARITY_EN: XOR of data bits, inverted when PARITY_ODD), STOP_BITS stop bits of 1.
- No idle gap between bytes inside a frame.
- States: IDLE → START → DATA (8 bits) → PARITY (skipped if disabled) → STOP (STOP_BITS bits) → START of next byte, or → DONE after last byte → IDLE.
- DONE lasts one cycle: frame_done=1, uart_tx=1, busy=0, send_ready=0. IDLE: send_ready=1.

## Timing
- Handshake at cycle T: uart_tx falls (start bit) at T+1; busy=1, send_ready=0 from T+1.
- Every bit is held exactly CLKS_PER_BIT cycles.
- Frame length in cycles = (HEADER_EN + NUM_BYTES + CHECKSUM_EN) × (9 + PARITY_EN + STOP_BITS) × CLKS_PER_BIT.
- frame_done pulses in the cycle after the final stop bit's last cycle; send_ready returns the following cycle. Minimum gap between frames on the line with send_valid held high: 2 cycles of idle-high.
- data_array changes after the handshake do not affect the frame in flight.
- All outputs registered.

## Structure
- Package uart_frame_pkg: state enum (IDLE, START, DATA, PARITY, STOP, DONE), function for parity bit, function for checksum over a byte vector, localparam helper for CLKS_PER_BIT.
- Sub-module uart_byte_tx: single-byte serialiser with baud counter, parity and stop-bit handling, start/done handshake; uart_frame_tx sequences header/payload/checksum bytes into it.

## Test plan
- CLOCK_FREQ=1000, BAUD_RATE=100, defaults otherwise; data_array=32'h01020304, one-cycle send_valid -> line decodes A5 01 02 03 04 0A; frame exactly 600 cycles; frame_done one pulse at cycle 601 after handshake.
- Same, HEADER_EN=0, CHECKSUM_EN=0, PARITY_EN=1, PARITY_ODD=0, data_array=32'h03070000 -> parity bits 0,1,0,0; 4×11×10=440 cycles.
- STOP_BITS=2, PARITY_ODD=1, PARITY_EN=1, NUM_BYTES=1, data 8'hFF, no header/checksum -> bits 0,1×8,parity 1, 1,1; 120 cycles.
- send_valid held high, data changed mid-frame -> first frame carries latched data; second frame starts exactly 2 idle cycles after first ends; pulses during busy ignored.
- rst asserted mid-DATA of byte 2 -> uart_tx=1, busy=0, send_ready=1 immediately (same cycle, async); next handshake sends a complete clean frame.
- Checksum wrap: NUM_BYTES=4, data 32'hFFFFFF02 -> checksum 8'hFF (0x2FF mod 256).
